// File: rtl/aes_io_sequencer.sv
// ---------------------------------------------------------------------------
// aes_io_sequencer
//   Streaming bridge between the 32-bit coprocessor datapath and a 128-bit
//   AES core. It collects four plaintext words, fires a one-cycle encrypt
//   pulse, waits for the core's done with a timeout, captures the ciphertext
//   and streams it back out as four 32-bit words.
//
//   Ports
//     clock, reset            clock; asynchronous active-high reset
//     key_wr_en/idx/data      key word writes (idx 0 = bits [127:96]), only
//                             taken while idle (busy=0)
//     s_valid/s_ready/s_data  plaintext word stream, first beat = [127:96]
//     m_valid/m_ready/m_data  ciphertext word stream, first beat = [127:96]
//     encrypt                 one-cycle start pulse to the core
//     core_block, core_key    registered operands, stable from ARM to next ARM
//     core_done, core_dout    core completion level and ciphertext
//     busy                    high in ARM, WAIT or DRAIN
//     timeout_err             sticky, set when the core never finishes
//     blocks_done             completed-block counter
//
//   Optional feature macro: AES_IO_PERF_EN
//     defined   -> blocks_done counts completed blocks, saturating at 16'hFFFF
//     undefined -> blocks_done is tied to zero
// ---------------------------------------------------------------------------
module aes_io_sequencer #(
   parameter int WAIT_LIMIT = 63,
   parameter int CNT_W      = $clog2(WAIT_LIMIT + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          key_wr_en,
   input  logic [1:0]    key_wr_idx,
   input  logic [31:0]   key_wr_data,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [31:0]   s_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [31:0]   m_data,
   output logic          encrypt,
   output logic [127:0]  core_block,
   output logic [127:0]  core_key,
   input  logic          core_done,
   input  logic [127:0]  core_dout,
   output logic          busy,
   output logic          timeout_err,
   output logic [15:0]   blocks_done
);

   typedef enum logic [1:0] {LOAD, ARM, WAIT, DRAIN} state_t;

   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_LIMIT - 1);

   state_t           state, state_nx;
   logic [1:0]       beat, beat_nx;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;

   // Word views: index 3 is the most significant word, so word[~beat]
   // walks [127:96] first and [31:0] last.
   logic [3:0][31:0] key_words, key_nx;
   logic [3:0][31:0] block_words, block_nx;
   logic [3:0][31:0] result_words;

   logic s_fire, m_fire, capture, wait_expire, arm_load;

   assign s_ready = (state == LOAD);
   assign m_valid = (state == DRAIN);
   assign encrypt = (state == ARM);
   assign busy    = (state != LOAD);
   assign m_data  = result_words[~beat];

   assign s_fire   = s_valid & s_ready;
   assign m_fire   = m_valid & m_ready;
   assign arm_load = s_fire & (beat == 2'd3);

   // Next-state logic
   always_comb begin
      state_nx    = state;
      beat_nx     = beat;
      wait_cnt_nx = wait_cnt;
      capture     = 1'b0;
      wait_expire = 1'b0;
      case (state)
         LOAD: begin
            if (s_fire) begin
               beat_nx = beat + 2'd1;
               if (beat == 2'd3) state_nx = ARM;
            end
         end
         ARM: begin
            state_nx    = WAIT;
            wait_cnt_nx = '0;
         end
         WAIT: begin
            wait_cnt_nx = wait_cnt + CNT_W'(1);
            // The first WAIT cycle may still see the previous block's done
            // level, so completion is only honoured from the second cycle.
            // A done on the limit cycle takes priority over the timeout.
            if ((wait_cnt != '0) && core_done) begin
               capture  = 1'b1;
               state_nx = DRAIN;
            end else if (wait_cnt == LAST_WAIT) begin
               wait_expire = 1'b1;
               state_nx    = LOAD;
            end
         end
         DRAIN: begin
            if (m_fire) begin
               beat_nx = beat + 2'd1;
               if (beat == 2'd3) state_nx = LOAD;
            end
         end
         default: state_nx = LOAD;
      endcase
   end

   // Key and block next values; the last plaintext word and a same-cycle key
   // write are forwarded so core operands are complete on the ARM cycle.
   always_comb begin
      key_nx = key_words;
      if (key_wr_en && !busy) key_nx[~key_wr_idx] = key_wr_data;
      block_nx = block_words;
      if (s_fire) block_nx[~beat] = s_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= LOAD;
         beat     <= '0;
         wait_cnt <= '0;
      end else begin
         state    <= state_nx;
         beat     <= beat_nx;
         wait_cnt <= wait_cnt_nx;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         key_words    <= '0;
         block_words  <= '0;
         result_words <= '0;
         core_block   <= '0;
         core_key     <= '0;
         timeout_err  <= 1'b0;
      end else begin
         key_words   <= key_nx;
         block_words <= block_nx;
         if (arm_load) begin
            core_block <= block_nx;
            core_key   <= key_nx;
         end
         if (capture) result_words <= core_dout;
         if (s_fire && (beat == 2'd0)) timeout_err <= 1'b0;
         else if (wait_expire)         timeout_err <= 1'b1;
      end
   end

`ifdef AES_IO_PERF_EN
   logic [15:0] blk_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         blk_cnt <= '0;
      else if (m_fire && (beat == 2'd3) && (blk_cnt != 16'hFFFF))
         blk_cnt <= blk_cnt + 16'd1;
   end

   assign blocks_done = blk_cnt;
`else
   assign blocks_done = 16'h0000;
`endif

endmodule

// File: tb/tb_aes_io_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_io_sequencer
//   Self-checking bench for aes_io_sequencer. A behavioural core model
//   answers encrypt requests after LAT cycles (known-answer table for the
//   FIPS-197 C.1 vector, a simple stand-in cipher otherwise) and keeps its
//   done level high while idle. The scoreboard derives every expected word
//   from the plaintext/key the bench itself supplied.
// ---------------------------------------------------------------------------
module tb_aes_io_sequencer;
   localparam int WAIT_LIMIT = 63;
   localparam int LAT        = 42;

   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clock = 1'b0;
   logic         reset;
   logic         key_wr_en;
   logic [1:0]   key_wr_idx;
   logic [31:0]  key_wr_data;
   logic         s_valid, s_ready;
   logic [31:0]  s_data;
   logic         m_valid, m_ready;
   logic [31:0]  m_data;
   logic         encrypt;
   logic [127:0] core_block, core_key;
   logic         core_done = 1'b0;
   logic [127:0] core_dout = '0;
   logic         busy, timeout_err;
   logic [15:0]  blocks_done;

   always #5 clock = ~clock;

   aes_io_sequencer #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
      .clock(clock), .reset(reset),
      .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .encrypt(encrypt), .core_block(core_block), .core_key(core_key),
      .core_done(core_done), .core_dout(core_dout),
      .busy(busy), .timeout_err(timeout_err), .blocks_done(blocks_done)
   );

   function automatic logic [127:0] cipher(input logic [127:0] b, input logic [127:0] k);
      if (b == PT_C1 && k == KEY_C1) return CT_C1;
      return {b[95:0], b[127:96]} ^ k ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
   endfunction

   // Core model: done stays high through the cycle after encrypt, then drops
   // and rises again LAT edges after the encrypt edge.
   int           core_cnt = 0;
   bit           core_hang = 1'b0;
   logic [127:0] lat_blk = '0, lat_key = '0;
   always @(posedge clock) begin
      if (encrypt) begin
         core_cnt <= LAT;
         lat_blk  <= core_block;
         lat_key  <= core_key;
      end else if (core_cnt > 0) begin
         core_cnt <= core_cnt - 1;
         if (core_cnt == 1 && !core_hang) begin
            core_done <= 1'b1;
            core_dout <= cipher(lat_blk, lat_key);
         end else begin
            core_done <= 1'b0;
         end
      end
   end

   // Protocol monitors
   int   enc_cycles = 0, mv_cycles = 0;
   bit   enc_double = 1'b0, overlap = 1'b0;
   logic enc_prev = 1'b0;
   always @(negedge clock) begin
      if (encrypt) enc_cycles <= enc_cycles + 1;
      if (encrypt && enc_prev) enc_double <= 1'b1;
      if (s_ready && m_valid) overlap <= 1'b1;
      if (m_valid) mv_cycles <= mv_cycles + 1;
      enc_prev <= encrypt;
   end

   int          checks = 0, errors = 0;
   int          enc_exp = 0, blocks_exp = 0;
   logic [31:0] kmodel [4];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] model_key();
      return {kmodel[0], kmodel[1], kmodel[2], kmodel[3]};
   endfunction

   function automatic logic [15:0] perf_exp();
`ifdef AES_IO_PERF_EN
      return 16'(blocks_exp);
`else
      return 16'h0000;
`endif
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic write_key(input int idx, input logic [31:0] data, input bit taken);
      key_wr_en   = 1'b1;
      key_wr_idx  = 2'(idx);
      key_wr_data = data;
      tick();
      key_wr_en = 1'b0;
      if (taken) kmodel[idx] = data;
   endtask

   task automatic send_block(input logic [127:0] blk, input bit gaps);
      for (int i = 0; i < 4; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         s_valid = 1'b1;
         s_data  = blk[(3-i)*32 +: 32];
         check("s_ready_load", 128'(s_ready), 128'(1));
         tick();
         s_valid = 1'b0;
         if (i == 0) check("terr_clear", 128'(timeout_err), 128'(0));
      end
      enc_exp++;
   endtask

   task automatic recv_block(input logic [127:0] exp, input int hold, input int nbeats,
                             output int lat);
      lat = 0;
      for (int i = 0; i < nbeats; i++) begin
         int n = 0;
         while (!m_valid && n < 200) begin
            tick();
            n++;
         end
         if (i == 0) lat = n;
         check("m_valid_wait", 128'(m_valid), 128'(1));
         m_ready = 1'b0;
         for (int h = 0; h < hold; h++) begin
            check("bp_data", 128'(m_data), 128'(exp[(3-i)*32 +: 32]));
            check("bp_s_ready", 128'(s_ready), 128'(0));
            tick();
         end
         check("m_data", 128'(m_data), 128'(exp[(3-i)*32 +: 32]));
         m_ready = 1'b1;
         tick();
         m_ready = 1'b0;
      end
      if (nbeats == 4) begin
         blocks_exp++;
         check("drain_done", 128'({m_valid, s_ready}), 128'(2'b01));
         check("blocks_done", 128'(blocks_done), 128'(perf_exp()));
      end
   endtask

   initial begin
      int lat, n;
      int mv_before;
      logic [127:0] blk;
      reset = 1'b1;
      key_wr_en = 1'b0; key_wr_idx = '0; key_wr_data = '0;
      s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      for (int i = 0; i < 4; i++) kmodel[i] = '0;
      repeat (3) tick();

      // Reset state
      check("rst_s_ready", 128'(s_ready), 128'(1));
      check("rst_outs", 128'({m_valid, encrypt, busy, timeout_err}), 128'(0));
      check("rst_m_data", 128'(m_data), 128'(0));
      check("rst_blocks", 128'(blocks_done), 128'(0));
      check("rst_core_block", core_block, 128'(0));
      check("rst_core_key", core_key, 128'(0));
      reset = 1'b0;
      tick();

      // C.1 known-answer vector
      for (int i = 0; i < 4; i++) write_key(i, KEY_C1[(3-i)*32 +: 32], 1'b1);
      send_block(PT_C1, 1'b0);
      check("core_key", core_key, KEY_C1);
      check("core_block", core_block, PT_C1);
      recv_block(CT_C1, 0, 4, lat);
      check("latency", 128'(lat), 128'(LAT + 2));
      check("enc_count_c1", 128'(enc_cycles), 128'(1));

      // Back-to-back: done is still high from the previous block
      blk = 128'hfedcba98_76543210_0f1e2d3c_4b5a6978;
      send_block(blk, 1'b0);
      recv_block(cipher(blk, model_key()), 0, 4, lat);
      check("latency_b2b", 128'(lat), 128'(LAT + 2));

      // Backpressure: five stalled cycles per beat
      blk = {$urandom, $urandom, $urandom, $urandom};
      send_block(blk, 1'b0);
      recv_block(cipher(blk, model_key()), 5, 4, lat);

      // Randomised blocks, idle-time key updates, gaps and stalls
      for (int it = 0; it < 8; it++) begin
         if ($urandom_range(0, 1) == 1) write_key($urandom_range(0, 3), $urandom, 1'b1);
         blk = {$urandom, $urandom, $urandom, $urandom};
         send_block(blk, 1'b1);
         recv_block(cipher(blk, model_key()), $urandom_range(0, 3), 4, lat);
         check("latency_rand", 128'(lat), 128'(LAT + 2));
      end

      // Timeout: core never finishes
      core_hang = 1'b1;
      mv_before = mv_cycles;
      send_block(PT_C1, 1'b0);
      n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      check("timeout_cycles", 128'(n), 128'(WAIT_LIMIT + 1));
      check("timeout_err", 128'(timeout_err), 128'(1));
      check("timeout_load", 128'({s_ready, busy}), 128'(2'b10));
      check("timeout_no_mvalid", 128'(mv_cycles), 128'(mv_before));
      core_hang = 1'b0;
      blk = {$urandom, $urandom, $urandom, $urandom};
      send_block(blk, 1'b0);
      recv_block(cipher(blk, model_key()), 1, 4, lat);

      // Key write while busy is dropped
      for (int i = 0; i < 4; i++) write_key(i, KEY_C1[(3-i)*32 +: 32], 1'b1);
      send_block(PT_C1, 1'b0);
      repeat (5) tick();
      check("busy_wait", 128'(busy), 128'(1));
      write_key(0, 32'hFFFFFFFF, 1'b0);
      recv_block(CT_C1, 0, 4, lat);
      send_block(PT_C1, 1'b0);
      recv_block(CT_C1, 0, 4, lat);

      // Reset in DRAIN after beat 1
      blk = {$urandom, $urandom, $urandom, $urandom};
      send_block(blk, 1'b0);
      recv_block(cipher(blk, model_key()), 0, 2, lat);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_outs", 128'({m_valid, s_ready, busy}), 128'(3'b010));
      check("rst_mid_blocks", 128'(blocks_done), 128'(0));
      tick();
      check("rst_mid_next", 128'({m_valid, s_ready}), 128'(2'b01));
      reset = 1'b0;
      blocks_exp = 0;
      for (int i = 0; i < 4; i++) kmodel[i] = '0;
      tick();
      for (int b = 0; b < 2; b++) begin
         blk = {$urandom, $urandom, $urandom, $urandom};
         send_block(blk, 1'b0);
         recv_block(cipher(blk, model_key()), 0, 4, lat);
      end
      check("blocks_after_two", 128'(blocks_done), 128'(perf_exp()));

      // Global protocol properties
      tick();
      check("enc_single_cycle", 128'(enc_double), 128'(0));
      check("enc_total", 128'(enc_cycles), 128'(enc_exp));
      check("s_m_overlap", 128'(overlap), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
